// File: rtl/synth_cfg_writer.sv
// Queues 16-bit config writes and serializes them into byte transfers on the
// synth's strobe port, with timing the receiver's 2-flop sync can capture.
module synth_cfg_writer #(
  parameter int ADDR_BITS       = 3,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int SETUP_CYCLES    = 2,
  parameter int HOLD_CYCLES     = 4,
  parameter int RECOVER_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [15:0]          wr_data,
  input  logic [1:0]           wr_be,
  output logic                 cfg_strobe,
  output logic [ADDR_BITS-1:0] cfg_addr,
  output logic                 cfg_addr0,
  output logic [7:0]           cfg_data,
  output logic                 busy
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int WORD_W = ADDR_BITS + 18;

  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD    = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER
  } state_t;

  state_t                     state;
  logic [3:0]                 timer;
  logic [WORD_W-1:0]          fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push;
  logic                       pop;
  logic [ADDR_BITS-1:0]       head_addr;
  logic [15:0]                head_data;
  logic [1:0]                 head_be;
  logic [7:0]                 word_hi;
  logic                       word_has_hi;

  assign wr_ready = (count != FULL_COUNT);
  assign push     = wr_valid && wr_ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign {head_addr, head_data, head_be} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {wr_addr, wr_data, wr_be};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Bus fields only move when entering SETUP, so they stay put through
  // the strobe pulse and the whole recovery window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      cfg_strobe  <= 1'b0;
      cfg_addr    <= '0;
      cfg_addr0   <= 1'b0;
      cfg_data    <= '0;
      busy        <= 1'b0;
      word_hi     <= '0;
      word_has_hi <= 1'b0;
    end else begin
      busy <= (state != IDLE) || (count != '0);
      case (state)
        IDLE: begin
          if (count != '0) begin
            word_hi     <= head_data[15:8];
            word_has_hi <= head_be[1];
            if (head_be != 2'b00) begin
              state     <= SETUP;
              timer     <= SETUP_LOAD;
              cfg_addr  <= head_addr;
              cfg_addr0 <= !head_be[0];
              cfg_data  <= head_be[0] ? head_data[7:0] : head_data[15:8];
            end
          end
        end
        SETUP: begin
          if (timer == '0) begin
            state      <= STROBE;
            timer      <= HOLD_LOAD;
            cfg_strobe <= 1'b1;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        STROBE: begin
          if (timer == '0) begin
            state      <= RECOVER;
            timer      <= RECOVER_LOAD;
            cfg_strobe <= 1'b0;
          end else begin
            timer <= timer - 4'd1;
          end
        end
        RECOVER: begin
          if (timer == '0) begin
            if (!cfg_addr0 && word_has_hi) begin
              state     <= SETUP;
              timer     <= SETUP_LOAD;
              cfg_addr0 <= 1'b1;
              cfg_data  <= word_hi;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synth_cfg_writer.sv
// Bench for synth_cfg_writer: a default-timing instance for directed cases and a
// fast-timing instance (hold/recover 3) driven randomly, both against a timeline model.
module tb_synth_cfg_writer;

  localparam int S0 = 2, H0 = 4, R0 = 4;
  localparam int S1 = 2, H1 = 3, R1 = 3;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v [2];
  logic [2:0]  a [2];
  logic [15:0] d [2];
  logic [1:0]  b [2];
  logic        rdy [2];
  logic        stb [2];
  logic [2:0]  ca [2];
  logic        ca0 [2];
  logic [7:0]  cd [2];
  logic        bsy [2];

  synth_cfg_writer #(.SETUP_CYCLES(S0), .HOLD_CYCLES(H0), .RECOVER_CYCLES(R0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(v[0]), .wr_ready(rdy[0]), .wr_addr(a[0]),
    .wr_data(d[0]), .wr_be(b[0]), .cfg_strobe(stb[0]), .cfg_addr(ca[0]),
    .cfg_addr0(ca0[0]), .cfg_data(cd[0]), .busy(bsy[0])
  );

  synth_cfg_writer #(.SETUP_CYCLES(S1), .HOLD_CYCLES(H1), .RECOVER_CYCLES(R1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(v[1]), .wr_ready(rdy[1]), .wr_addr(a[1]),
    .wr_data(d[1]), .wr_be(b[1]), .cfg_strobe(stb[1]), .cfg_addr(ca[1]),
    .cfg_addr0(ca0[1]), .cfg_data(cd[1]), .busy(bsy[1])
  );

  int checks = 0;
  int failures = 0;
  int rel = 0;

  // Model: each popped word owns a timeline of nbytes*(S+H+R) edges starting at its pop edge.
  word_t mq [2][4];
  int    mhead [2] = '{0, 0};
  int    mcnt [2] = '{0, 0};
  int    idle_at [2] = '{0, 0};
  int    cur_p [2] = '{0, 0};
  int    cur_n [2] = '{0, 0};
  word_t cur_w [2];
  bit    have_w [2] = '{0, 0};
  bit    busy_m [2] = '{0, 0};
  int    edge_no = 0;
  logic [15:0] exp_mem [2][8] = '{default: '0};
  int    exp_bytes [2] = '{0, 0};

  logic [15:0] rx_mem [2][8] = '{default: '0};
  int    rx_bytes [2] = '{0, 0};
  logic  s1 [2] = '{0, 0};
  logic  s2 [2] = '{0, 0};
  logic  s3 [2] = '{0, 0};
  int    rises [2] = '{0, 0};
  logic  stb_q [2] = '{0, 0};

  function automatic int tSetup(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int tHold(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int tPeriod(input int i);
    return (i == 0) ? (S0 + H0 + R0) : (S1 + H1 + R1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_no = 0;
      for (int i = 0; i < 2; i++) begin
        mhead[i] = 0; mcnt[i] = 0; idle_at[i] = 0; have_w[i] = 0; busy_m[i] = 0;
      end
    end else begin
      edge_no++;
      for (int i = 0; i < 2; i++) begin
        bit do_pop, do_push;
        word_t w;
        int nb;
        busy_m[i] = ((edge_no - 1) < idle_at[i]) || (mcnt[i] > 0);
        do_pop  = (mcnt[i] > 0) && ((edge_no - 1) >= idle_at[i]);
        do_push = v[i] && (mcnt[i] < 4);
        if (do_push) begin
          w.addr = a[i]; w.data = d[i]; w.be = b[i];
          mq[i][(mhead[i] + mcnt[i]) % 4] = w;
        end
        if (do_pop) begin
          w = mq[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % 4;
          nb = int'(w.be[0]) + int'(w.be[1]);
          if (nb > 0) begin
            cur_w[i] = w; cur_p[i] = edge_no; cur_n[i] = nb; have_w[i] = 1;
            idle_at[i] = edge_no + nb * tPeriod(i);
            if (w.be[0]) exp_mem[i][w.addr][7:0] = w.data[7:0];
            if (w.be[1]) exp_mem[i][w.addr][15:8] = w.data[15:8];
            exp_bytes[i] += nb;
          end
        end
        mcnt[i] += int'(do_push) - int'(do_pop);
      end
    end
  end

  task automatic expectedBus(input int i, output logic es, output logic [2:0] ea,
                             output logic e0, output logic [7:0] ed);
    int dd, k, off;
    logic hi;
    es = 0; ea = '0; e0 = 0; ed = '0;
    if (have_w[i]) begin
      dd  = edge_no - cur_p[i];
      k   = dd / tPeriod(i);
      off = dd % tPeriod(i);
      if (k > cur_n[i] - 1) k = cur_n[i] - 1;
      es = (dd < cur_n[i] * tPeriod(i)) && (off >= tSetup(i)) && (off < tSetup(i) + tHold(i));
      hi = (k == 1) || !cur_w[i].be[0];
      ea = cur_w[i].addr;
      e0 = hi;
      ed = hi ? cur_w[i].data[15:8] : cur_w[i].data[7:0];
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic es, e0;
      logic [2:0] ea;
      logic [7:0] ed;
      expectedBus(i, es, ea, e0, ed);
      checkOutput($sformatf("ready%0d", i), 32'(rdy[i]), 32'(mcnt[i] < 4));
      checkOutput($sformatf("busy%0d", i), 32'(bsy[i]), 32'(busy_m[i]));
      checkOutput($sformatf("strobe%0d", i), 32'(stb[i]), 32'(es));
      checkOutput($sformatf("addr%0d", i), 32'(ca[i]), 32'(ea));
      checkOutput($sformatf("addr0_%0d", i), 32'(ca0[i]), 32'(e0));
      checkOutput($sformatf("data%0d", i), 32'(cd[i]), 32'(ed));
    end
  end

  // Receiver side of the synth: two sync flops plus rising-edge detect.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s2[i] && !s3[i]) begin
        rx_mem[i][ca[i]] <= ca0[i] ? {cd[i], rx_mem[i][ca[i]][7:0]} : {rx_mem[i][ca[i]][15:8], cd[i]};
        rx_bytes[i] <= rx_bytes[i] + 1;
      end
      s1[i] <= stb[i];
      s2[i] <= s1[i];
      s3[i] <= s2[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (stb[i] && !stb_q[i]) rises[i]++;
      stb_q[i] = stb[i];
    end
  end

  task automatic applyStimulus(input int i, input logic [2:0] addr, input logic [15:0] data,
                               input logic [1:0] be);
    int waited = 0;
    v[i] = 1'b1; a[i] = addr; d[i] = data; b[i] = be;
    while (!rdy[i] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy[i]) begin
      checks++; failures++;
      $display("[TB] FAIL push_timeout inst=%0d ready=%0b required=1", i, rdy[i]);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    v[i] = 1'b0;
  endtask

  task automatic stepTo(input int k);
    while (rel < k) begin
      @(negedge clk);
      rel++;
    end
  endtask

  task automatic waitIdle(input int i, input int limit);
    int waited = 0;
    while ((bsy[i] || mcnt[i] != 0 || stb[i]) && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (bsy[i] || mcnt[i] != 0) begin
      checks++; failures++;
      $display("[TB] FAIL idle_timeout inst=%0d busy=%0b required=0", i, bsy[i]);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0;
    int waited;
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; a[i] = '0; d[i] = '0; b[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 32'(rdy[0]), 32'd1);
    checkOutput("rst_busy", 32'(bsy[0]), 32'd0);
    checkOutput("rst_strobe", 32'(stb[0]), 32'd0);
    checkOutput("rst_cfg", {21'd0, ca[0], ca0[0], cd[0]}, 32'd0);

    $display("[TB] two-byte word at default timing");
    applyStimulus(0, 3'd5, 16'hA37C, 2'b11);
    rel = 0;
    stepTo(2);  checkOutput("t1_strobe_n2", 32'(stb[0]), 32'd0);
    stepTo(3);  checkOutput("t1_strobe_n3", 32'(stb[0]), 32'd1);
    checkOutput("t1_addr", 32'(ca[0]), 32'd5);
    checkOutput("t1_addr0_lo", 32'(ca0[0]), 32'd0);
    checkOutput("t1_data_lo", 32'(cd[0]), 32'h7C);
    stepTo(6);  checkOutput("t1_strobe_n6", 32'(stb[0]), 32'd1);
    stepTo(7);  checkOutput("t1_strobe_n7", 32'(stb[0]), 32'd0);
    stepTo(12); checkOutput("t1_strobe_n12", 32'(stb[0]), 32'd0);
    stepTo(13); checkOutput("t1_strobe_n13", 32'(stb[0]), 32'd1);
    checkOutput("t1_addr0_hi", 32'(ca0[0]), 32'd1);
    checkOutput("t1_data_hi", 32'(cd[0]), 32'hA3);
    stepTo(16); checkOutput("t1_strobe_n16", 32'(stb[0]), 32'd1);
    stepTo(17); checkOutput("t1_strobe_n17", 32'(stb[0]), 32'd0);
    stepTo(21); checkOutput("t1_busy_n21", 32'(bsy[0]), 32'd1);
    stepTo(22); checkOutput("t1_busy_n22", 32'(bsy[0]), 32'd0);
    checkOutput("t1_rx_word5", 32'(rx_mem[0][5]), 32'hA37C);

    $display("[TB] high-byte-only word and empty byte enables");
    r0 = rises[0];
    applyStimulus(0, 3'd2, 16'h12FF, 2'b10);
    rel = 0;
    stepTo(3);
    checkOutput("t2_strobe_n3", 32'(stb[0]), 32'd1);
    checkOutput("t2_addr0", 32'(ca0[0]), 32'd1);
    checkOutput("t2_data", 32'(cd[0]), 32'h12);
    waitIdle(0, 100);
    checkOutput("t2_pulses", 32'(rises[0] - r0), 32'd1);
    r0 = rises[0];
    applyStimulus(0, 3'd6, 16'hBEEF, 2'b00);
    rel = 0;
    checkOutput("t2_be0_busy_n0", 32'(bsy[0]), 32'd0);
    stepTo(1); checkOutput("t2_be0_busy_n1", 32'(bsy[0]), 32'd1);
    stepTo(2); checkOutput("t2_be0_busy_n2", 32'(bsy[0]), 32'd0);
    stepTo(12);
    checkOutput("t2_be0_pulses", 32'(rises[0] - r0), 32'd0);

    $display("[TB] burst into a full FIFO");
    for (int j = 0; j < 5; j++) begin
      applyStimulus(0, 3'(j + 1), 16'($urandom), 2'b11);
    end
    checkOutput("t3_full_ready", 32'(rdy[0]), 32'd0);
    waited = 0;
    while (!(mcnt[0] == 3 && edge_no >= idle_at[0]) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t3_reach_cnt3", 32'(mcnt[0]), 32'd3);
    applyStimulus(0, 3'd7, 16'h5AA5, 2'b01);
    checkOutput("t3_same_edge_ready", 32'(rdy[0]), 32'd1);
    checkOutput("t3_same_edge_cnt", 32'(mcnt[0]), 32'd3);
    waitIdle(0, 400);
    checkOutput("t3_rx_bytes", 32'(rx_bytes[0]), 32'(exp_bytes[0]));
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t3_rx_word%0d", k), 32'(rx_mem[0][k]), 32'(exp_mem[0][k]));
    end

    $display("[TB] asynchronous reset during a strobe");
    for (int j = 0; j < 4; j++) begin
      applyStimulus(0, 3'(j), 16'($urandom), 2'b11);
    end
    waited = 0;
    while (!stb[0] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t4_in_strobe", 32'(stb[0]), 32'd1);
    checkOutput("t4_queued", 32'(mcnt[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t4_strobe_drop", 32'(stb[0]), 32'd0);
    checkOutput("t4_ready", 32'(rdy[0]), 32'd1);
    checkOutput("t4_busy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rises[0];
    repeat (40) @(negedge clk);
    checkOutput("t4_no_strobes", 32'(rises[0] - r0), 32'd0);
    checkOutput("t4_ready_after", 32'(rdy[0]), 32'd1);
    checkOutput("t4_busy_after", 32'(bsy[0]), 32'd0);

    $display("[TB] random writes at hold=3 recover=3");
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 12)) @(negedge clk);
      end
      applyStimulus(1, 3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)));
    end
    waitIdle(1, 2000);
    checkOutput("t5_rx_bytes", 32'(rx_bytes[1]), 32'(exp_bytes[1]));
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t5_rx_word%0d", k), 32'(rx_mem[1][k]), 32'(exp_mem[1][k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
